// File: rtl/req_page_splitter_if.sv
// rtl/req_page_splitter_if.sv - request-in / sub-request-out bundle around the page splitter
interface req_page_splitter_if #(
  parameter int VADDR_BITS = 48,
  parameter int LEN_BITS   = 28,
  parameter int PID_BITS   = 6,
  parameter int DEST_BITS  = 4,
  parameter int VFID_BITS  = 1
);
  logic                  s_req_valid;
  logic                  s_req_ready;
  logic [VADDR_BITS-1:0] s_req_vaddr;
  logic [LEN_BITS-1:0]   s_req_len;
  logic                  s_req_stream;
  logic                  s_req_sync;
  logic                  s_req_ctl;
  logic                  s_req_host;
  logic [DEST_BITS-1:0]  s_req_dest;
  logic [PID_BITS-1:0]   s_req_pid;
  logic [VFID_BITS-1:0]  s_req_vfid;

  logic                  m_req_valid;
  logic                  m_req_ready;
  logic [VADDR_BITS-1:0] m_req_vaddr;
  logic [LEN_BITS-1:0]   m_req_len;
  logic                  m_req_stream;
  logic                  m_req_sync;
  logic                  m_req_ctl;
  logic                  m_req_host;
  logic                  m_req_last;
  logic [DEST_BITS-1:0]  m_req_dest;
  logic [PID_BITS-1:0]   m_req_pid;
  logic [VFID_BITS-1:0]  m_req_vfid;

  // master: the environment issuing parents and consuming chunks
  modport master (
    output s_req_valid, s_req_vaddr, s_req_len, s_req_stream, s_req_sync, s_req_ctl,
           s_req_host, s_req_dest, s_req_pid, s_req_vfid, m_req_ready,
    input  s_req_ready, m_req_valid, m_req_vaddr, m_req_len, m_req_stream, m_req_sync,
           m_req_ctl, m_req_host, m_req_last, m_req_dest, m_req_pid, m_req_vfid
  );

  // slave: the splitter itself
  modport slave (
    input  s_req_valid, s_req_vaddr, s_req_len, s_req_stream, s_req_sync, s_req_ctl,
           s_req_host, s_req_dest, s_req_pid, s_req_vfid, m_req_ready,
    output s_req_ready, m_req_valid, m_req_vaddr, m_req_len, m_req_stream, m_req_sync,
           m_req_ctl, m_req_host, m_req_last, m_req_dest, m_req_pid, m_req_vfid
  );
endinterface

// File: rtl/req_page_splitter.sv
// rtl/req_page_splitter.sv - splits virtual requests into chunks that never cross a page
// boundary or exceed the max chunk size, so each chunk needs exactly one TLB lookup.
module req_page_splitter #(
  parameter int VADDR_BITS     = 48,
  parameter int LEN_BITS       = 28,
  parameter int PID_BITS       = 6,
  parameter int DEST_BITS      = 4,
  parameter int VFID_BITS      = 1,
  parameter int PG_BITS        = 12,
  parameter int MAX_CHUNK_BITS = 12
) (
  input  logic        aclk,
  input  logic        srst,
  req_page_splitter_if.slave bus,
  output logic [31:0] stat_req_cnt,
  output logic [31:0] stat_chunk_cnt,
  output logic [31:0] stat_drop_cnt
);

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

  localparam logic [LEN_BITS:0] ONE        = {{LEN_BITS{1'b0}}, 1'b1};
  localparam logic [LEN_BITS:0] PAGE_BYTES = ONE << PG_BITS;
  localparam logic [LEN_BITS:0] MAX_BYTES  = ONE << MAX_CHUNK_BITS;

  state_t                state_q, state_d;
  logic [VADDR_BITS-1:0] vaddr_q, vaddr_d;
  logic [LEN_BITS-1:0]   rem_q, rem_d;
  logic                  stream_q, stream_d;
  logic                  sync_q, sync_d;
  logic                  ctl_q, ctl_d;
  logic                  host_q, host_d;
  logic                  first_q, first_d;
  logic [DEST_BITS-1:0]  dest_q, dest_d;
  logic [PID_BITS-1:0]   pid_q, pid_d;
  logic [VFID_BITS-1:0]  vfid_q, vfid_d;
  logic [31:0]           req_cnt_q, req_cnt_d;
  logic [31:0]           chunk_cnt_q, chunk_cnt_d;
  logic [31:0]           drop_cnt_q, drop_cnt_d;

  logic [LEN_BITS:0]     page_room;
  logic [LEN_BITS:0]     lim;
  logic [LEN_BITS-1:0]   chunk_len;
  logic                  chunk_last;
  logic                  s_hs;
  logic                  m_hs;

  // Chunk size depends only on registered state; one extra bit holds a full page.
  always_comb begin
    page_room = PAGE_BYTES - {{(LEN_BITS + 1 - PG_BITS){1'b0}}, vaddr_q[PG_BITS-1:0]};
    lim       = (page_room < MAX_BYTES) ? page_room : MAX_BYTES;
    if ({1'b0, rem_q} <= lim) begin
      chunk_len  = rem_q;
      chunk_last = 1'b1;
    end else begin
      chunk_len  = lim[LEN_BITS-1:0];
      chunk_last = 1'b0;
    end
  end

  assign s_hs = bus.s_req_valid && (state_q == IDLE);
  assign m_hs = bus.m_req_ready && (state_q == SPLIT);

  always_comb begin
    state_d     = state_q;
    vaddr_d     = vaddr_q;
    rem_d       = rem_q;
    stream_d    = stream_q;
    sync_d      = sync_q;
    ctl_d       = ctl_q;
    host_d      = host_q;
    first_d     = first_q;
    dest_d      = dest_q;
    pid_d       = pid_q;
    vfid_d      = vfid_q;
    req_cnt_d   = req_cnt_q;
    chunk_cnt_d = chunk_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    case (state_q)
      IDLE: begin
        if (s_hs) begin
          if (bus.s_req_len != '0) begin
            state_d   = SPLIT;
            vaddr_d   = bus.s_req_vaddr;
            rem_d     = bus.s_req_len;
            stream_d  = bus.s_req_stream;
            sync_d    = bus.s_req_sync;
            ctl_d     = bus.s_req_ctl;
            host_d    = bus.s_req_host;
            dest_d    = bus.s_req_dest;
            pid_d     = bus.s_req_pid;
            vfid_d    = bus.s_req_vfid;
            first_d   = 1'b1;
            req_cnt_d = req_cnt_q + 32'd1;
          end else begin
            drop_cnt_d = drop_cnt_q + 32'd1;
          end
        end
      end
      SPLIT: begin
        if (m_hs) begin
          chunk_cnt_d = chunk_cnt_q + 32'd1;
          first_d     = 1'b0;
          if (chunk_last) begin
            state_d = IDLE;
          end else begin
            vaddr_d = vaddr_q + VADDR_BITS'(chunk_len);
            rem_d   = rem_q - chunk_len;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q     <= IDLE;
      vaddr_q     <= '0;
      rem_q       <= '0;
      stream_q    <= 1'b0;
      sync_q      <= 1'b0;
      ctl_q       <= 1'b0;
      host_q      <= 1'b0;
      first_q     <= 1'b0;
      dest_q      <= '0;
      pid_q       <= '0;
      vfid_q      <= '0;
      req_cnt_q   <= '0;
      chunk_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      vaddr_q     <= vaddr_d;
      rem_q       <= rem_d;
      stream_q    <= stream_d;
      sync_q      <= sync_d;
      ctl_q       <= ctl_d;
      host_q      <= host_d;
      first_q     <= first_d;
      dest_q      <= dest_d;
      pid_q       <= pid_d;
      vfid_q      <= vfid_d;
      req_cnt_q   <= req_cnt_d;
      chunk_cnt_q <= chunk_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // rem_q is zero out of reset, so last is gated by state to keep idle outputs clear.
  assign bus.s_req_ready  = (state_q == IDLE);
  assign bus.m_req_valid  = (state_q == SPLIT);
  assign bus.m_req_vaddr  = vaddr_q;
  assign bus.m_req_len    = chunk_len;
  assign bus.m_req_last   = (state_q == SPLIT) && chunk_last;
  assign bus.m_req_ctl    = ctl_q && bus.m_req_last;
  assign bus.m_req_sync   = sync_q && first_q;
  assign bus.m_req_stream = stream_q;
  assign bus.m_req_host   = host_q;
  assign bus.m_req_dest   = dest_q;
  assign bus.m_req_pid    = pid_q;
  assign bus.m_req_vfid   = vfid_q;

  assign stat_req_cnt   = req_cnt_q;
  assign stat_chunk_cnt = chunk_cnt_q;
  assign stat_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_req_page_splitter.sv
// tb/tb_req_page_splitter.sv - randomized self-checking bench for req_page_splitter
module tb_req_page_splitter;

  typedef struct packed {
    logic [47:0] va;
    logic [27:0] ln;
    logic        last;
    logic        ctl;
    logic        sync;
    logic        stream;
    logic        host;
    logic [3:0]  dest;
    logic [5:0]  pid;
    logic        vfid;
  } chunk_t;

  logic        aclk = 1'b0;
  logic        srst;
  logic [31:0] stat_req_cnt, stat_chunk_cnt, stat_drop_cnt;

  int     n_cmp = 0;
  int     n_fail = 0;
  int     exp_req, exp_chunk, exp_drop;
  chunk_t exp_q[$];
  chunk_t obs_q[$];
  int     obs_cyc[$];
  logic   after_ready, after_valid;
  bit     timed_out;

  always #5 aclk = ~aclk;

  req_page_splitter_if bus ();

  req_page_splitter dut (
    .aclk           (aclk),
    .srst           (srst),
    .bus            (bus),
    .stat_req_cnt   (stat_req_cnt),
    .stat_chunk_cnt (stat_chunk_cnt),
    .stat_drop_cnt  (stat_drop_cnt)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    bus.s_req_valid = 1'b0; bus.s_req_vaddr = '0; bus.s_req_len = '0;
    bus.s_req_stream = 1'b0; bus.s_req_sync = 1'b0; bus.s_req_ctl = 1'b0;
    bus.s_req_host = 1'b0; bus.s_req_dest = '0; bus.s_req_pid = '0; bus.s_req_vfid = '0;
    bus.m_req_ready = 1'b0;
    step();
    step();
    srst = 1'b0;
    exp_req = 0; exp_chunk = 0; exp_drop = 0;
  endtask

  // Reference: walk the parent range, cutting at page edges and at the 4 KiB cap.
  function automatic void build_exp(input chunk_t r);
    longint unsigned addr, rem, room, c;
    bit first;
    chunk_t e;
    exp_q.delete();
    addr = r.va; rem = r.ln; first = 1'b1;
    while (rem > 0) begin
      room = 4096 - (addr % 4096);
      c = rem;
      if (room < c) c = room;
      if (c > 4096) c = 4096;
      e = r;
      e.va = 48'(addr);
      e.ln = 28'(c);
      e.last = (c == rem);
      e.ctl = r.ctl && e.last;
      e.sync = r.sync && first;
      exp_q.push_back(e);
      addr = (addr + c) % (64'd1 << 48);
      rem = rem - c;
      first = 1'b0;
    end
    exp_chunk += exp_q.size();
  endfunction

  task automatic drive_req(input chunk_t r);
    bus.s_req_valid = 1'b1;
    bus.s_req_vaddr = r.va; bus.s_req_len = r.ln;
    bus.s_req_stream = r.stream; bus.s_req_sync = r.sync; bus.s_req_ctl = r.ctl;
    bus.s_req_host = r.host; bus.s_req_dest = r.dest; bus.s_req_pid = r.pid;
    bus.s_req_vfid = r.vfid;
    step();
    bus.s_req_valid = 1'b0;
    if (r.ln == 0) exp_drop++; else exp_req++;
  endtask

  task automatic collect(input int ready_pct);
    chunk_t o;
    obs_q.delete();
    obs_cyc.delete();
    timed_out = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      bus.m_req_ready = ($urandom_range(0, 99) < ready_pct);
      if (bus.m_req_valid && bus.m_req_ready) begin
        o.va = bus.m_req_vaddr; o.ln = bus.m_req_len; o.last = bus.m_req_last;
        o.ctl = bus.m_req_ctl; o.sync = bus.m_req_sync; o.stream = bus.m_req_stream;
        o.host = bus.m_req_host; o.dest = bus.m_req_dest; o.pid = bus.m_req_pid;
        o.vfid = bus.m_req_vfid;
        obs_q.push_back(o);
        obs_cyc.push_back(cyc);
      end
      step();
      if (obs_q.size() > 0 && obs_q[obs_q.size()-1].last) begin
        after_ready = bus.s_req_ready;
        after_valid = bus.m_req_valid;
        bus.m_req_ready = 1'b0;
        return;
      end
    end
    bus.m_req_ready = 1'b0;
    timed_out = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.s_req_ready, bus.m_req_valid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_handshake: got rdy/vld=%b required 10", {bus.s_req_ready, bus.m_req_valid});
    end
    n_cmp++;
    if ({bus.m_req_vaddr, bus.m_req_len, bus.m_req_last, bus.m_req_ctl, bus.m_req_sync} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got va=%h len=%h last=%b required zeros", bus.m_req_vaddr, bus.m_req_len, bus.m_req_last);
    end
    n_cmp++;
    if ({stat_req_cnt, stat_chunk_cnt, stat_drop_cnt} !== 96'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d required 0/0/0", stat_req_cnt, stat_chunk_cnt, stat_drop_cnt);
    end
  endtask

  task automatic test_single_page();
    chunk_t r = '0;
    r.va = 48'h1000; r.ln = 28'h1000; r.ctl = 1'b1; r.sync = 1'b1;
    r.stream = 1'b1; r.dest = 4'h5; r.pid = 6'h2a; r.vfid = 1'b1;
    build_exp(r);
    drive_req(r);
    n_cmp++;
    if (bus.m_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL first_valid_latency: got %b required 1", bus.m_req_valid);
    end
    collect(100);
    n_cmp++;
    if (timed_out || obs_q.size() != 1) begin
      n_fail++; $display("FAIL single_count: got %0d chunks (timeout=%0d) required 1", obs_q.size(), timed_out);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL single_chunk%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (stat_req_cnt !== 32'd1 || stat_chunk_cnt !== 32'd1) begin
      n_fail++; $display("FAIL single_stats: got req=%0d chunk=%0d required 1/1", stat_req_cnt, stat_chunk_cnt);
    end
  endtask

  task automatic test_page_cross();
    chunk_t r = '0;
    r.va = 48'h0FF0; r.ln = 28'h40; r.ctl = 1'b1; r.host = 1'b1; r.pid = 6'h11;
    build_exp(r);
    drive_req(r);
    collect(100);
    n_cmp++;
    if (timed_out || obs_q.size() != 2) begin
      n_fail++; $display("FAIL cross_count: got %0d chunks (timeout=%0d) required 2", obs_q.size(), timed_out);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL cross_chunk%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    chunk_t r = '0;
    r.va = 48'h0; r.ln = 28'h2800; r.sync = 1'b1; r.ctl = 1'b1;
    build_exp(r);
    drive_req(r);
    collect(100);
    n_cmp++;
    if (timed_out || obs_q.size() != 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d chunks (timeout=%0d) required 3", obs_q.size(), timed_out);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || obs_cyc[i] !== i) begin
        n_fail++; $display("FAIL b2b_chunk%0d: got %h at cycle %0d required %h at cycle %0d", i, obs_q[i], obs_cyc[i], exp_q[i], i);
      end
    end
    n_cmp++;
    if ({after_ready, after_valid} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_ready_after: got rdy/vld=%b required 10", {after_ready, after_valid});
    end
  endtask

  task automatic test_stall();
    chunk_t r = '0;
    r.va = 48'h0F00; r.ln = 28'h300; r.stream = 1'b1;
    build_exp(r);
    drive_req(r);
    bus.m_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({bus.m_req_valid, bus.m_req_vaddr, bus.m_req_len} !== {1'b1, 48'h0F00, 28'h100}) begin
        n_fail++; $display("FAIL stall_hold%0d: got vld=%b va=%h len=%h required 1/0f00/100", i, bus.m_req_valid, bus.m_req_vaddr, bus.m_req_len);
      end
      step();
    end
    collect(100);
    n_cmp++;
    if (timed_out || obs_q.size() != 2) begin
      n_fail++; $display("FAIL stall_count: got %0d chunks (timeout=%0d) required 2", obs_q.size(), timed_out);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL stall_chunk%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_drop();
    chunk_t r = '0;
    r.va = 48'h0123_4567_8000; r.ln = 28'h0; r.ctl = 1'b1;
    build_exp(r);
    drive_req(r);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({bus.m_req_valid, bus.s_req_ready} !== 2'b01) begin
        n_fail++; $display("FAIL drop_idle%0d: got vld/rdy=%b required 01", i, {bus.m_req_valid, bus.s_req_ready});
      end
      step();
    end
    n_cmp++;
    if (stat_drop_cnt !== 32'(exp_drop) || exp_drop != 1) begin
      n_fail++; $display("FAIL drop_count: got %0d required 1", stat_drop_cnt);
    end
  endtask

  task automatic test_wrap();
    chunk_t r = '0;
    r.va = 48'hFFFF_FFFF_FF80; r.ln = 28'h100; r.ctl = 1'b1; r.sync = 1'b1;
    build_exp(r);
    drive_req(r);
    collect(100);
    n_cmp++;
    if (timed_out || obs_q.size() != 2 || obs_q[obs_q.size()-1].va !== 48'h0) begin
      n_fail++; $display("FAIL wrap_count: got %0d chunks (timeout=%0d) required 2 ending at va 0", obs_q.size(), timed_out);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL wrap_chunk%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    chunk_t r;
    for (int n = 0; n < 40; n++) begin
      r = '0;
      r.va = {16'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) r.va[11:0] = 12'h0;
      r.ln = ($urandom_range(0, 9) == 0) ? 28'h0 : 28'($urandom_range(1, 28'h3000));
      r.ctl = 1'($urandom); r.sync = 1'($urandom); r.stream = 1'($urandom);
      r.host = 1'($urandom); r.dest = 4'($urandom); r.pid = 6'($urandom); r.vfid = 1'($urandom);
      build_exp(r);
      drive_req(r);
      if (exp_q.size() == 0) begin
        step();
        continue;
      end
      collect(60);
      n_cmp++;
      if (timed_out || obs_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d chunks (timeout=%0d) required %0d", n, obs_q.size(), timed_out, exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand%0d_chunk%0d: got %h required %h", n, i, obs_q[i], exp_q[i]);
        end
      end
      if (timed_out) return;
    end
    n_cmp++;
    if (stat_req_cnt !== 32'(exp_req) || stat_chunk_cnt !== 32'(exp_chunk) || stat_drop_cnt !== 32'(exp_drop)) begin
      n_fail++; $display("FAIL rand_stats: got %0d/%0d/%0d required %0d/%0d/%0d", stat_req_cnt, stat_chunk_cnt, stat_drop_cnt, exp_req, exp_chunk, exp_drop);
    end
  endtask

  task automatic test_reset_mid();
    chunk_t r = '0;
    r.va = 48'h0; r.ln = 28'h2800; r.sync = 1'b1;
    build_exp(r);
    drive_req(r);
    bus.m_req_ready = 1'b1;
    step();
    n_cmp++;
    if ({bus.m_req_valid, bus.m_req_vaddr} !== {1'b1, 48'h1000}) begin
      n_fail++; $display("FAIL midrst_second_chunk: got vld=%b va=%h required 1/1000", bus.m_req_valid, bus.m_req_vaddr);
    end
    srst = 1'b1;
    bus.m_req_ready = 1'b0;
    step();
    n_cmp++;
    if ({bus.m_req_valid, bus.s_req_ready} !== 2'b01 || {stat_req_cnt, stat_chunk_cnt, stat_drop_cnt} !== 96'd0) begin
      n_fail++; $display("FAIL midrst_clear: got vld/rdy=%b cnt=%0d/%0d/%0d required 01 and 0/0/0", {bus.m_req_valid, bus.s_req_ready}, stat_req_cnt, stat_chunk_cnt, stat_drop_cnt);
    end
    srst = 1'b0;
    exp_req = 0; exp_chunk = 0; exp_drop = 0;
    step();
    r = '0;
    r.va = 48'h0FF0; r.ln = 28'h40; r.ctl = 1'b1; r.dest = 4'h9;
    build_exp(r);
    drive_req(r);
    collect(100);
    n_cmp++;
    if (timed_out || obs_q.size() != 2) begin
      n_fail++; $display("FAIL midrst_fresh_count: got %0d chunks (timeout=%0d) required 2", obs_q.size(), timed_out);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL midrst_fresh_chunk%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (stat_req_cnt !== 32'd1 || stat_chunk_cnt !== 32'd2) begin
      n_fail++; $display("FAIL midrst_stats: got req=%0d chunk=%0d required 1/2", stat_req_cnt, stat_chunk_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_page();
    test_page_cross();
    test_back_to_back();
    test_stall();
    test_drop();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/req_page_splitter.md
Name: req_page_splitter

Overview:
- Sits directly downstream of the user-logic request interface (the 96-bit packed request: vaddr, len, stream, sync, ctl, host, dest, pid, vfid) and upstream of the TLB/DMA translation stage.
- Splits each virtual request into sub-requests that never cross a small-page boundary (2^PG_BITS) and never exceed 2^MAX_CHUNK_BITS bytes.
- The downstream translator therefore performs exactly one TLB lookup per sub-request.

Parameters:
- VADDR_BITS, 48, virtual address width
- LEN_BITS, 28, length field width
- PID_BITS, 6, process id width
- DEST_BITS, 4, destination width
- VFID_BITS, 1, region id width (N_REGIONS_BITS)
- PG_BITS, 12, page-size order; page = 4096 B
- MAX_CHUNK_BITS, 12, max chunk order (PMTU 4096 B); must satisfy MAX_CHUNK_BITS <= LEN_BITS

Ports:
- aclk  in  1  clock
- srst  in  1  synchronous active-high reset
- s_req_valid  in  1  input request valid
- s_req_ready  out  1  input request ready
- s_req_vaddr  in  VADDR_BITS  start virtual address
- s_req_len  in  LEN_BITS  length in bytes
- s_req_stream, s_req_sync, s_req_ctl, s_req_host  in  1 each  request flags
- s_req_dest  in  DEST_BITS  destination
- s_req_pid  in  PID_BITS  process id
- s_req_vfid  in  VFID_BITS  region id
- m_req_valid  out  1  sub-request valid
- m_req_ready  in  1  sub-request ready
- m_req_vaddr  out  VADDR_BITS  chunk address
- m_req_len  out  LEN_BITS  chunk length
- m_req_stream, m_req_sync, m_req_ctl, m_req_host  out  1 each  chunk flags
- m_req_last  out  1  final chunk of the parent request
- m_req_dest, m_req_pid, m_req_vfid  out  as input  copied from the parent request
- stat_req_cnt, stat_chunk_cnt, stat_drop_cnt  out  32 each  statistics counters

Behaviour:
- Single clock domain.
- All flops reset synchronously on srst=1.
- Reset values: state=IDLE, s_req_ready=1, m_req_valid=0, all other m_req_* outputs=0, all counters=0.

FSM states: IDLE, SPLIT.
- IDLE:
  - s_req_ready=1, m_req_valid=0.
  - On s_req_valid & s_req_ready with len!=0: latch cur_vaddr=vaddr, rem=len, and all flags/ids; set first=1; go to SPLIT; stat_req_cnt++.
  - On a handshake with len==0: request is consumed and dropped, no output; stat_drop_cnt++; stay in IDLE.
- SPLIT:
  - s_req_ready=0, m_req_valid=1.
  - chunk = min(rem, 2^PG_BITS - cur_vaddr[PG_BITS-1:0], 2^MAX_CHUNK_BITS), computed in LEN_BITS+1 bits.
  - Outputs:
    - m_req_vaddr=cur_vaddr
    - m_req_len=chunk
    - m_req_last=(chunk==rem)
    - m_req_ctl=ctl & last
    - m_req_sync=sync & first
    - stream, host, dest, pid, vfid copied unchanged.
  - On m_req_valid & m_req_ready:
    - stat_chunk_cnt++, first=0.
    - If last: go to IDLE.
    - Else: cur_vaddr += chunk (modulo 2^VADDR_BITS) and rem -= chunk.

Timing:
- First m_req_valid appears one cycle after the input handshake.
- Throughput is one chunk per cycle while m_req_ready=1.
- s_req_ready rises the cycle after the last chunk's handshake, so one idle cycle occurs between parent requests.

Handshake and output rules:
- All m_req_* outputs derive from registered state only; there is no combinational path from s_req_* or m_req_ready.
- Outputs stay stable while m_req_valid & !m_req_ready.

Boundary conditions:
- Page-aligned address with rem >= 4096: chunk is exactly 4096.
- Address wrap at 2^VADDR_BITS: wraps silently.
- Counters wrap at 2^32.
- srst asserted mid-SPLIT: the in-flight request is abandoned; next cycle state=IDLE, m_req_valid=0, counters=0.

Test Plan:
- vaddr=0x1000, len=0x1000, ctl=1, sync=1 -> one chunk (0x1000, 0x1000), last=1, ctl=1, sync=1; stat_req_cnt=1, stat_chunk_cnt=1.
- vaddr=0x0FF0, len=0x40, ctl=1 -> chunks (0x0FF0, 0x10, last=0, ctl=0) then (0x1000, 0x30, last=1, ctl=1).
- vaddr=0x0, len=0x2800, m_req_ready held 1 -> chunks 0x1000, 0x1000, 0x800 on three consecutive cycles; sync only on the first; s_req_ready=1 the cycle after the third.
- vaddr=0x0F00, len=0x300, m_req_ready=0 for 5 cycles -> m_req_valid=1 with vaddr=0x0F00, len=0x100 held stable all 5 cycles; then second chunk (0x1000, 0x200).
- len=0 request -> no m_req_valid; stat_drop_cnt=1; s_req_ready stays 1.
- srst pulsed during the second chunk of a 0x2800 request -> next cycle m_req_valid=0, s_req_ready=1, all counters 0; a fresh request then splits correctly.
